// File: rtl/noc_pkg.sv
// Shared definitions for the router output-port schedulers.
// Port indices, flit-id bit positions, scheduler state encoding and a
// one-hot to index helper used wherever a grant vector must be turned
// back into a port number.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int IDX_W  = 3;

  // Input port indices, also the bit order of req/grant vectors.
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;

  // Bit positions inside a 3-bit flit id.
  localparam int HDR  = 0;
  localparam int BODY = 1;
  localparam int TAIL = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NPORTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational five-way round-robin pick.
// Ports:
//   eligible : per-port request vector (bit order L,N,E,W,S)
//   last     : index of the most recently served port
//   winner   : one-hot winner, first eligible port after 'last' with wrap
//   valid    : at least one port is eligible
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] eligible,
  input  logic [IDX_W-1:0]  last,
  output logic [NPORTS-1:0] winner,
  output logic              valid
);

  logic [3:0]       sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    // Scan last+1 .. last+5; 'last' never exceeds 4, so one conditional
    // subtraction is enough for the modulo.
    for (int k = 1; k <= NPORTS; k++) begin
      sum  = {1'b0, last} + 4'(k);
      cand = (sum >= 4'(NPORTS)) ? IDX_W'(sum - 4'(NPORTS)) : sum[IDX_W-1:0];
      if (!valid && eligible[cand]) begin
        winner[cand] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_scheduler.sv
// Wormhole scheduler for one router output port shared by five inputs.
// A header flit wins round-robin arbitration, the grant is held until the
// tail flit moves, downstream flow is limited by a credit counter, and a
// watchdog forces a release when the holder stops presenting flits.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-input flit valid (L=0,N=1,E=2,W=3,S=4)
//   flit_id      : 3 bits per input {tail, body, header}
//   credit_in    : one-cycle pulse returning one downstream credit
//   grant        : registered one-hot grant, 0 when idle
//   xfer         : a flit moves from the holder to the output this cycle
//   credits      : current downstream credit count
//   busy         : packet in progress
//   timeout_err  : one-cycle pulse on a forced release
module noc_output_scheduler
  import noc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 255,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     req,
  input  logic [3*NPORTS-1:0]   flit_id,
  input  logic                  credit_in,
  output logic [NPORTS-1:0]     grant,
  output logic                  xfer,
  output logic [CW-1:0]         credits,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int              WD_W     = 12;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);

  state_t             state;
  logic [IDX_W-1:0]   holder;
  logic [IDX_W-1:0]   last;
  logic [WD_W-1:0]    wdog;

  logic [NPORTS-1:0]  hdr_bits;
  logic [NPORTS-1:0]  tail_bits;
  logic [NPORTS-1:0]  body_bits;
  logic               body_unused;
  logic [NPORTS-1:0]  eligible;
  logic [NPORTS-1:0]  winner;
  logic               arb_valid;
  logic               hold_req;
  logic               hold_tail;
  logic               tail_done;
  logic               wd_fire;

  always_comb begin
    hdr_bits  = '0;
    tail_bits = '0;
    body_bits = '0;
    for (int i = 0; i < NPORTS; i++) begin
      hdr_bits[i]  = flit_id[3*i + HDR];
      body_bits[i] = flit_id[3*i + BODY];
      tail_bits[i] = flit_id[3*i + TAIL];
    end
  end

  // The body marker carries no scheduling meaning: anything that is not a
  // tail keeps the grant.
  assign body_unused = ^body_bits;

  // Only header flits may open a packet; stray body/tail flits are ignored.
  assign eligible = req & hdr_bits;

  rr_arbiter u_arb (
    .eligible (eligible),
    .last     (last),
    .winner   (winner),
    .valid    (arb_valid)
  );

  assign busy      = (state == HOLD);
  assign hold_req  = req[holder];
  assign hold_tail = tail_bits[holder];
  assign xfer      = busy & hold_req & (credits != '0);
  assign tail_done = xfer & hold_tail;
  // Only idle cycles of the holder reach the limit; credit stalls keep
  // req high and therefore never fire the watchdog.
  assign wd_fire   = busy & ~hold_req & (wdog == WD_LAST);

  // Packet FSM, grant, pointer and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this clock edge.
      state       <= IDLE;
      grant       <= '0;
      holder      <= '0;
      last        <= IDX_W'(PORT_S);
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state  <= HOLD;
            grant  <= winner;
            holder <= onehot_to_idx(winner);
            wdog   <= '0;
          end
        end
        HOLD: begin
          if (tail_done) begin
            state <= IDLE;
            grant <= '0;
            last  <= holder;
          end else if (wd_fire) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= holder;
            timeout_err <= 1'b1;
          end else if (xfer) begin
            wdog <= '0;
          end else if (!hold_req) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream credits: a simultaneous send and return cancel out; a
  // return into a full counter is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else begin
      case ({xfer, credit_in})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   if (credits != CRED_MAX) credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Directed bench for noc_output_scheduler. Stimulus pushes the expected
// holder/credit pair of every flit transfer and every expected timeout
// pulse into queues; a monitor on the falling edge pops and compares
// whenever the DUT shows xfer or timeout_err.
module tb_noc_output_scheduler;
  import noc_pkg::*;

  localparam int CREDITS = 4;
  localparam int TIMEOUT = 255;
  localparam int CW      = $clog2(CREDITS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        req;
  logic [14:0]       flit_id;
  logic              credit_in;
  logic [4:0]        grant;
  logic              xfer;
  logic [CW-1:0]     credits;
  logic              busy;
  logic              timeout_err;

  noc_output_scheduler #(
    .CREDITS (CREDITS),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .credit_in   (credit_in),
    .grant       (grant),
    .xfer        (xfer),
    .credits     (credits),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    grant;
    logic [CW-1:0] credits;
  } xfer_exp_t;

  xfer_exp_t xq[$];
  int        tq[$];
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fid(input int port, input logic [2:0] code);
    flit_id[3*port +: 3] = code;
  endtask

  task automatic expect_xfer(input logic [4:0] g, input logic [CW-1:0] c);
    xfer_exp_t e;
    e.grant   = g;
    e.credits = c;
    xq.push_back(e);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req       = '0;
    flit_id   = '0;
    credit_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every transfer and every timeout pulse must match an entry.
  initial begin
    xfer_exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (xfer === 1'b1) begin
          check("xfer_expected", 32'(xq.size() != 0), 1);
          if (xq.size() != 0) begin
            e = xq.pop_front();
            check("xfer_grant", grant, e.grant);
            check("xfer_credits", credits, e.credits);
          end
        end
        if (timeout_err === 1'b1) begin
          check("timeout_expected", 32'(tq.size() != 0), 1);
          if (tq.size() != 0) begin
            void'(tq.pop_front());
            check("timeout_grant", grant, 5'b00000);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req       = '0;
    flit_id   = '0;
    credit_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_grant", grant, 5'b00000);
    check("rst_busy", busy, 0);
    check("rst_credits", credits, 4);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_xfer", xfer, 0);
    tick();
    tick();
    rst = 1'b0;

    // 1: four-flit packet from L drains all credits.
    req = 5'b00001;
    set_fid(PORT_L, 3'b001);
    tick();
    check("t1_grant", grant, 5'b00001);
    check("t1_busy", busy, 1);
    expect_xfer(5'b00001, 3'd4);
    tick();
    set_fid(PORT_L, 3'b010);
    expect_xfer(5'b00001, 3'd3);
    tick();
    expect_xfer(5'b00001, 3'd2);
    tick();
    set_fid(PORT_L, 3'b100);
    expect_xfer(5'b00001, 3'd1);
    tick();
    req     = '0;
    flit_id = '0;
    check("t1_idle_grant", grant, 5'b00000);
    check("t1_idle_busy", busy, 0);
    check("t1_credits_empty", credits, 0);
    credit_in = 1'b1;
    repeat (4) tick();
    check("t1_credits_refill", credits, 4);
    tick();
    check("t1_credits_saturate", credits, 4);
    credit_in = 1'b0;

    // 2: all five inputs with single-flit packets, credits returned every cycle.
    apply_reset();
    req       = 5'b11111;
    flit_id   = 15'b101_101_101_101_101;
    credit_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [4:0] g;
      g = 5'b00001 << (k % 5);
      tick();
      check("t2_grant", grant, g);
      expect_xfer(g, 3'd4);
      tick();
      check("t2_bubble", grant, 5'b00000);
    end
    req       = '0;
    flit_id   = '0;
    credit_in = 1'b0;
    tick();

    // 3: holder N stalls on zero credits without tripping the watchdog.
    apply_reset();
    req = 5'b00010;
    set_fid(PORT_N, 3'b001);
    tick();
    check("t3_grant", grant, 5'b00010);
    expect_xfer(5'b00010, 3'd4);
    tick();
    set_fid(PORT_N, 3'b010);
    expect_xfer(5'b00010, 3'd3);
    tick();
    expect_xfer(5'b00010, 3'd2);
    tick();
    expect_xfer(5'b00010, 3'd1);
    tick();
    repeat (300) tick();
    check("t3_stall_grant", grant, 5'b00010);
    check("t3_stall_credits", credits, 0);
    check("t3_stall_xfer", xfer, 0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    set_fid(PORT_N, 3'b100);
    expect_xfer(5'b00010, 3'd1);
    tick();
    req     = '0;
    flit_id = '0;
    check("t3_end_grant", grant, 5'b00000);
    check("t3_end_credits", credits, 0);

    // 4: holder E goes silent; watchdog releases it and W is served next.
    apply_reset();
    req = 5'b01100;
    set_fid(PORT_E, 3'b001);
    set_fid(PORT_W, 3'b101);
    tick();
    check("t4_grant_e", grant, 5'b00100);
    req = 5'b01000;
    repeat (254) tick();
    check("t4_still_held", grant, 5'b00100);
    check("t4_no_early_timeout", timeout_err, 0);
    tq.push_back(1);
    tick();
    check("t4_released", grant, 5'b00000);
    check("t4_timeout_err", timeout_err, 1);
    tick();
    check("t4_grant_w", grant, 5'b01000);
    check("t4_timeout_pulse", timeout_err, 0);
    expect_xfer(5'b01000, 3'd4);
    tick();
    req     = '0;
    flit_id = '0;
    check("t4_end_grant", grant, 5'b00000);

    // 5: simultaneous xfer and credit return leave the count unchanged.
    apply_reset();
    req = 5'b00001;
    set_fid(PORT_L, 3'b001);
    tick();
    expect_xfer(5'b00001, 3'd4);
    tick();
    set_fid(PORT_L, 3'b010);
    expect_xfer(5'b00001, 3'd3);
    tick();
    check("t5_credits_2", credits, 2);
    credit_in = 1'b1;
    expect_xfer(5'b00001, 3'd2);
    tick();
    check("t5_credits_hold", credits, 2);
    credit_in = 1'b0;
    set_fid(PORT_L, 3'b100);
    expect_xfer(5'b00001, 3'd2);
    tick();
    req     = '0;
    flit_id = '0;
    check("t5_credits_1", credits, 1);
    credit_in = 1'b1;
    repeat (3) tick();
    check("t5_credits_full", credits, 4);
    tick();
    check("t5_credits_sat", credits, 4);
    credit_in = 1'b0;

    // 6: asynchronous reset in the middle of a packet.
    apply_reset();
    req = 5'b00001;
    set_fid(PORT_L, 3'b001);
    tick();
    expect_xfer(5'b00001, 3'd4);
    tick();
    set_fid(PORT_L, 3'b010);
    check("t6_busy_before", busy, 1);
    check("t6_credits_before", credits, 3);
    #2;
    rst     = 1'b1;
    req     = '0;
    flit_id = '0;
    #1;
    check("t6_async_grant", grant, 5'b00000);
    check("t6_async_busy", busy, 0);
    check("t6_async_credits", credits, 4);
    tick();
    rst     = 1'b0;
    req     = 5'b00011;
    flit_id = 15'b000_000_000_101_101;
    tick();
    check("t6_grant_l_first", grant, 5'b00001);
    expect_xfer(5'b00001, 3'd4);
    tick();
    req     = '0;
    flit_id = '0;
    check("t6_end_grant", grant, 5'b00000);

    repeat (3) tick();
    check("xfer_queue_empty", xq.size(), 0);
    check("timeout_queue_empty", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
